dmem_arbiter: RTL and testbench

Shares the single-port data memory between the processor's memory stage and the VGA snake/board reader. Processor accesses normally win. A starvation counter guarantees the VGA reader a slot by stalling the pipeline for one cycle. The block also steers the one-cycle-latency read data back to whichever requester owns it. It sits between `skeleton_proc`'s M stage, the VGA controller and the dmem RAM.

---
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the processor M stage and the VGA reader share one RAM port.
// A starvation counter forces a VGA slot, and a return tag steers read data back.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_req,
  input  logic              proc_wren,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_data,
  output logic              proc_stall,
  output logic              proc_rvalid,
  output logic [DATA_W-1:0] proc_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_PROC,
    OWN_VGA
  } owner_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic [7:0] starve_q, starve_d;
  logic       force_vga;
  logic       proc_gnt;
  logic       vga_gnt_w;

  // Every grant is gated by reset so nothing reaches the RAM while held.
  always_comb begin
    force_vga = reset && vga_req && proc_req
                && (starve_q == LIMIT);
    proc_gnt  = reset && proc_req && !force_vga;
    vga_gnt_w = reset && vga_req
                && (!proc_req || force_vga);
  end

  always_comb begin
    dmem_addr = vga_addr;
    dmem_data = '0;
    dmem_wren = 1'b0;
    if (proc_gnt) begin
      dmem_addr = proc_addr;
      dmem_data = proc_data;
      dmem_wren = proc_wren;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!vga_req || vga_gnt_w) begin
      starve_d = '0;
    end else if (starve_q < LIMIT) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Stores produce no read data, so they leave the tag empty.
  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      proc_gnt && !proc_wren: owner_d = OWN_PROC;
      vga_gnt_w:              owner_d = OWN_VGA;
      default:                owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign vga_gnt     = vga_gnt_w;
  assign proc_stall  = force_vga;
  assign proc_rvalid = (owner_q == OWN_PROC);
  assign vga_rvalid  = (owner_q == OWN_VGA);
  assign proc_rdata  = dmem_q;
  assign vga_rdata   = dmem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: hand vectors, corner sequences and a random run
// scored against a transaction-level model of grants, starvation and returns.
module tb_dmem_arbiter;

  localparam int LIM = 8;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        preq, pwr, vreq;
  logic [11:0] paddr, vaddr;
  logic [31:0] pdata;
  logic        stall, prv, vgnt, vrv, wren;
  logic [31:0] prd, vrd, ddata, dq;
  logic [11:0] daddr;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(rst_n),
    .proc_req(preq), .proc_wren(pwr),
    .proc_addr(paddr), .proc_data(pdata),
    .proc_stall(stall), .proc_rvalid(prv), .proc_rdata(prd),
    .vga_req(vreq), .vga_addr(vaddr), .vga_gnt(vgnt),
    .vga_rvalid(vrv), .vga_rdata(vrd),
    .dmem_addr(daddr), .dmem_data(ddata),
    .dmem_wren(wren), .dmem_q(dq)
  );

  always #5 clock = ~clock;

  // RAM device and the model's own view of memory contents
  logic [31:0] mem [0:4095];
  logic [31:0] shadow [0:4095];

  function automatic logic [31:0] seed_word(int i);
    return (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = seed_word(i);
      shadow[i] = seed_word(i);
    end
  end

  always @(posedge clock) begin
    if (wren) mem[daddr] <= ddata;
    dq <= mem[daddr];
  end

  // Model: wait = consecutive denied VGA cycles; pend = who gets data next
  int          wait_n = 0;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  bit          chk_en = 0;
  bit          m_stall = 0;
  bit          m_gnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit frc, eg, pg;
    frc = 0; eg = 0; pg = 0;
    if (chk_en) begin
      chk("m_proc_rvalid", 32'(prv), 32'(pend == 1));
      chk("m_vga_rvalid", 32'(vrv), 32'(pend == 2));
      if (pend == 1) chk("m_proc_rdata", prd, pend_data);
      if (pend == 2) chk("m_vga_rdata", vrd, pend_data);
    end
    if (rst_n) begin
      frc = vreq && preq && (wait_n == LIM);
      eg  = vreq && (!preq || frc);
      pg  = preq && !frc;
    end
    chk("m_vga_gnt", 32'(vgnt), 32'(eg));
    chk("m_stall", 32'(stall), 32'(frc));
    chk("m_wren", 32'(wren), 32'(pg && pwr));
    if (rst_n) begin
      chk("m_addr", 32'(daddr), 32'(pg ? paddr : vaddr));
      chk("m_wdata", ddata, pg ? pdata : 32'h0);
    end
    m_stall = frc;
    m_gnt   = eg;
    if (!rst_n) begin
      wait_n = 0;
      pend   = 0;
    end else begin
      pend = (pg && !pwr) ? 1 : (eg ? 2 : 0);
      pend_data = (pend == 1) ? shadow[paddr] : shadow[vaddr];
      if (pg && pwr) shadow[paddr] = pdata;
      if (vreq && !eg) wait_n = (wait_n < LIM) ? wait_n + 1 : LIM;
      else wait_n = 0;
    end
  endtask

  task automatic half();
    @(negedge clock);
  endtask

  task automatic fin();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit r, bit pq, bit pw, logic [11:0] pa,
                       logic [31:0] pd, bit vq, logic [11:0] va);
    rst_n = r; preq = pq; pwr = pw; paddr = pa;
    pdata = pd; vreq = vq; vaddr = va;
  endtask

  typedef struct {
    bit          rst, pq, pw;
    logic [11:0] pa;
    logic [31:0] pd;
    bit          vq;
    logic [11:0] va;
    bit          e_gnt, e_stall, e_wren, e_prv, e_vrv;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    bit got;
    vecs[0] = '{0, 1, 1, 12'h005, 32'h55, 1, 12'h006, 0, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 0, 0, 12'h000, 32'h0, 1, 12'h010, 1, 0, 0, 0, 0, 32'h0};
    vecs[2] = '{1, 1, 1, 12'h020, 32'h1234, 0, 12'h000, 0, 0, 1, 0, 1,
                32'hDEADBEEF};
    vecs[3] = '{1, 1, 0, 12'h020, 32'h0, 0, 12'h000, 0, 0, 0, 0, 0, 32'h0};
    vecs[4] = '{1, 0, 0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 0, 1, 0,
                32'h1234};
    vecs[5] = '{0, 1, 0, 12'h020, 32'h0, 0, 12'h000, 0, 0, 0, 0, 0, 32'h0};
    vecs[6] = '{1, 0, 0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 0, 0, 0, 32'h0};
    vecs[7] = '{1, 0, 0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 0, 0, 0, 32'h0};

    drive(0, 1, 0, 0, 0, 1, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk_en = 1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pq, vecs[i].pw, vecs[i].pa,
            vecs[i].pd, vecs[i].vq, vecs[i].va);
      half();
      chk($sformatf("v%0d_gnt", i), 32'(vgnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_wren", i), 32'(wren), 32'(vecs[i].e_wren));
      chk($sformatf("v%0d_prv", i), 32'(prv), 32'(vecs[i].e_prv));
      chk($sformatf("v%0d_vrv", i), 32'(vrv), 32'(vecs[i].e_vrv));
      if (vecs[i].e_prv) chk($sformatf("v%0d_prd", i), prd, vecs[i].e_data);
      if (vecs[i].e_vrv) chk($sformatf("v%0d_vrd", i), vrd, vecs[i].e_data);
      fin();
    end

    // Starvation: both requesters held high continuously
    drive(0, 0, 0, 0, 0, 0, 0);
    half(); fin();
    drive(1, 1, 0, 12'h003, 0, 1, 12'h010);
    for (int i = 0; i < 10; i++) begin
      half();
      chk($sformatf("st%0d_gnt", i), 32'(vgnt), 32'(i == 8));
      chk($sformatf("st%0d_stall", i), 32'(stall), 32'(i == 8));
      if (i == 9) begin
        chk("st9_vrv", 32'(vrv), 32'd1);
        chk("st9_vrd", vrd, 32'hDEADBEEF);
      end
      fin();
    end

    // Early drop: counter must restart from zero
    drive(0, 0, 0, 0, 0, 0, 0);
    half(); fin();
    drive(1, 1, 0, 12'h004, 0, 1, 12'h011);
    for (int i = 0; i < 5; i++) begin
      half(); fin();
    end
    vreq = 0;
    half(); fin();
    vreq = 1;
    n = 0;
    while (n < 20) begin
      half();
      got = vgnt;
      fin();
      if (got) break;
      n++;
    end
    chk("drop_wait", 32'(n), 32'd8);

    // Randomized traffic obeying both hold protocols
    drive(0, 0, 0, 0, 0, 0, 0);
    half(); fin();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if (!m_stall) begin
        preq  = ($urandom_range(0, 9) < 7);
        pwr   = $urandom_range(0, 1) != 0;
        paddr = 12'($urandom_range(0, 15));
        pdata = $urandom;
      end
      if (!vreq || m_gnt) begin
        vreq  = ($urandom_range(0, 9) < 6);
        vaddr = 12'($urandom_range(0, 15));
      end
      half(); fin();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
